// File: rtl/program_loader.sv
// program_loader: boot-time sequencer that assembles 32-bit instruction words
// from a length-prefixed, MSB-first byte stream, writes them to program memory
// and holds the core until the whole image has been written.
module program_loader #(
    parameter int MEMORY_DEPTH = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic                  ByteValid,
    input  logic [7:0]            ByteData,
    output logic                  ByteReady,
    output logic                  WriteEnable,
    output logic [DATA_WIDTH-1:0] WriteAddress,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  CpuHold,
    output logic                  Done,
    output logic                  Error
);

    // Index/length width is just wide enough to hold MEMORY_DEPTH itself.
    localparam int IW = $clog2(MEMORY_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_WORD,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state_q;
    logic [IW-1:0]           len_q;
    logic [IW-1:0]           idx_q;
    logic [1:0]              cnt_q;
    logic                    ready_q;
    logic                    we_q;
    logic [DATA_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    hold_q;
    logic                    done_q;
    logic                    error_q;

    logic                    xfer;
    logic                    len_bad;
    logic [IW-1:0]           idx_inc;

    // Handshake, length legality and next word index.
    assign xfer    = ByteValid && ready_q;
    assign len_bad = (ByteData == 8'd0) || (int'(ByteData) > MEMORY_DEPTH);
    assign idx_inc = idx_q + IW'(1);

    // Loader FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            // The write strobe is only ever a single-cycle pulse.
            we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        state_q <= S_LEN;
                        ready_q <= 1'b1;
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        if (len_bad) begin
                            state_q <= S_ERROR;
                            ready_q <= 1'b0;
                            error_q <= 1'b1;
                        end else begin
                            state_q <= S_WORD;
                            len_q   <= ByteData[IW-1:0];
                            idx_q   <= '0;
                            cnt_q   <= '0;
                        end
                    end
                end
                S_WORD: begin
                    if (xfer) begin
                        data_q <= {data_q[DATA_WIDTH-9:0], ByteData};
                        cnt_q  <= cnt_q + 2'd1;
                        // Fourth byte completes the word: stop accepting and strobe.
                        if (cnt_q == 2'd3) begin
                            state_q <= S_WRITE;
                            ready_q <= 1'b0;
                            we_q    <= 1'b1;
                            addr_q  <= DATA_WIDTH'({idx_q, 2'b00});
                        end
                    end
                end
                S_WRITE: begin
                    if (idx_inc == len_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        hold_q  <= 1'b0;
                    end else begin
                        state_q <= S_WORD;
                        idx_q   <= idx_inc;
                        ready_q <= 1'b1;
                    end
                end
                S_DONE, S_ERROR: begin
                    // A new load re-holds the core and clears both status flags.
                    if (Start) begin
                        state_q <= S_LEN;
                        ready_q <= 1'b1;
                        hold_q  <= 1'b1;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ByteReady    = ready_q;
    assign WriteEnable  = we_q;
    assign WriteAddress = addr_q;
    assign WriteData    = data_q;
    assign CpuHold      = hold_q;
    assign Done         = done_q;
    assign Error        = error_q;

endmodule
